// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the core load/store path (C)
//   and the external loader/debug port (X). One access is granted per cycle.
//   The core has priority, but a saturating starvation counter forces X to win
//   once it has been denied MAX_WAIT consecutive cycles. The memory returns
//   read data one cycle after the access. A one-entry tracker remembers who
//   owned that access so the response goes back to the right requester.
//
// Ports
//   clk, nrst                     clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata/c_be core request fields (held until c_gnt)
//   c_gnt                         core request accepted this cycle
//   c_rvalid/c_rdata              core response, 1 cycle after c_gnt
//   x_*                           same set of signals for the external port
//   m_en/m_we/m_addr/m_wdata/m_be memory access (driven 0 when idle)
//   m_rdata                       memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                nrst,

  // core requester
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,

  // external requester
  input  logic                x_req,
  input  logic                x_we,
  input  logic [ADDR_W-1:0]   x_addr,
  input  logic [DATA_W-1:0]   x_wdata,
  input  logic [DATA_W/8-1:0] x_be,
  output logic                x_gnt,
  output logic                x_rvalid,
  output logic [DATA_W-1:0]   x_rdata,

  // memory side
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // One requester's access bundle; the memory mux selects between two of these.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mreq_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_owner_q, resp_owner_d;  // 1 = X owns the response
  logic             resp_rd_q,    resp_rd_d;     // response carries read data

  // ---------------------------------------------------------------------------
  // Grant
  //   nrst gates the grant so nothing reaches the memory while reset is held,
  //   even if the requesters keep req asserted.
  // ---------------------------------------------------------------------------
  logic  x_win;
  logic  c_win;
  mreq_t c_bus;
  mreq_t x_bus;
  mreq_t m_bus;

  always_comb begin
    x_win = nrst && x_req && (!c_req || (wait_cnt_q == MAX_CNT));
    c_win = nrst && c_req && !x_win;
  end

  assign c_gnt = c_win;
  assign x_gnt = x_win;

  // ---------------------------------------------------------------------------
  // Memory mux: idle drives everything to 0 so m_we can never glitch high
  // without m_en.
  // ---------------------------------------------------------------------------
  always_comb begin
    c_bus = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
    x_bus = '{we: x_we, addr: x_addr, wdata: x_wdata, be: x_be};
    m_bus = '0;
    if (x_win)      m_bus = x_bus;
    else if (c_win) m_bus = c_bus;
  end

  assign m_en    = c_win | x_win;
  assign m_we    = m_bus.we;
  assign m_addr  = m_bus.addr;
  assign m_wdata = m_bus.wdata;
  assign m_be    = m_bus.be;

  // ---------------------------------------------------------------------------
  // Starvation counter
  //   Counts consecutive cycles X asked and was refused. Dropping x_req resets
  //   the count, so only an uninterrupted wait earns the forced win. The
  //   saturation branch is defensive: reaching MAX_CNT with x_req high always
  //   grants X in that same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (x_win || !x_req)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_CNT)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Response tracker
  //   Exactly one access can be in flight because the memory has a fixed
  //   1-cycle latency; each response belongs to the previous cycle's grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = m_en;
    resp_owner_d = x_win;
    resp_rd_d    = m_en && !m_bus.we;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing: write acks and the non-owner see zero data, so a stale
  // m_rdata never leaks to either requester.
  // ---------------------------------------------------------------------------
  logic c_own;
  logic x_own;

  always_comb begin
    c_own = resp_valid_q && !resp_owner_q;
    x_own = resp_valid_q &&  resp_owner_q;
  end

  assign c_rvalid = c_own;
  assign x_rvalid = x_own;
  assign c_rdata  = (c_own && resp_rd_q) ? m_rdata : '0;
  assign x_rdata  = (x_own && resp_rd_q) ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives scripted and random traffic into dmem_arbiter with a behavioural
//   1-cycle memory behind it. A negedge monitor predicts grants from the
//   arbitration rule, pushes the expected response into a queue on each grant
//   and pops/compares it when the response is due one cycle later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic          clk;
  logic          nrst;
  logic          c_req, c_we, x_req, x_we;
  logic [AW-1:0] c_addr, x_addr;
  logic [DW-1:0] c_wdata, x_wdata;
  logic [BW-1:0] c_be, x_be;
  logic          c_gnt, c_rvalid, x_gnt, x_rvalid;
  logic [DW-1:0] c_rdata, x_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .nrst(nrst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_be(x_be),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural memory (the device) and a separate reference image
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    mem[64]     = 32'hDEAD_BEEF;   // byte address 0x100
    ref_mem[64] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < BW; b++)
          if (m_be[b]) mem[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end else begin
        m_rdata <= mem[m_addr[9:2]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          own;   // 1 = X
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   m_wait = 0;       // model of the starvation count
  logic last_cg = 1'b0;
  logic last_xg = 1'b0;

  always @(negedge clk) begin
    logic          xw, cg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
    if (!nrst) begin
      chk("rst_c_gnt",    32'(c_gnt),    0);
      chk("rst_x_gnt",    32'(x_gnt),    0);
      chk("rst_m_en",     32'(m_en),     0);
      chk("rst_m_we",     32'(m_we),     0);
      chk("rst_c_rvalid", 32'(c_rvalid), 0);
      chk("rst_x_rvalid", 32'(x_rvalid), 0);
      chk("rst_c_rdata",  c_rdata,       0);
      chk("rst_x_rdata",  x_rdata,       0);
      q.delete();
      m_wait  = 0;
      last_cg = 1'b0;
      last_xg = 1'b0;
    end else begin
      // response side: the grant of the previous cycle
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("c_rvalid", 32'(c_rvalid), 32'(!e.own));
        chk("x_rvalid", 32'(x_rvalid), 32'(e.own));
        chk("c_rdata",  c_rdata, e.own ? 32'h0 : e.data);
        chk("x_rdata",  x_rdata, e.own ? e.data : 32'h0);
      end else begin
        chk("idle_c_rvalid", 32'(c_rvalid), 0);
        chk("idle_x_rvalid", 32'(x_rvalid), 0);
        chk("idle_c_rdata",  c_rdata, 0);
        chk("idle_x_rdata",  x_rdata, 0);
      end

      // grant side
      xw = x_req && (!c_req || m_wait == MW);
      cg = c_req && !xw;
      chk("c_gnt", 32'(c_gnt), 32'(cg));
      chk("x_gnt", 32'(x_gnt), 32'(xw));
      chk("m_en",  32'(m_en),  32'(cg | xw));
      if (cg || xw) begin
        chk("m_we",    32'(m_we), 32'(xw ? x_we : c_we));
        chk("m_addr",  m_addr,    xw ? x_addr : c_addr);
        chk("m_wdata", m_wdata,   xw ? x_wdata : c_wdata);
        chk("m_be",    32'(m_be), 32'(xw ? x_be : c_be));
        a = xw ? x_addr : c_addr;
        if (xw ? x_we : c_we) begin
          d = xw ? x_wdata : c_wdata;
          for (int b = 0; b < BW; b++)
            if ((xw ? x_be[b] : c_be[b])) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
          q.push_back('{own: xw, data: 32'h0});
        end else begin
          q.push_back('{own: xw, data: ref_mem[a[9:2]]});
        end
      end else begin
        chk("idle_m_we", 32'(m_we), 0);
      end

      if (xw || !x_req)     m_wait = 0;
      else if (m_wait < MW) m_wait = m_wait + 1;
      last_cg = c_gnt;
      last_xg = x_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_c(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    c_req = r; c_we = w; c_addr = a; c_wdata = d; c_be = be;
  endtask

  task automatic set_x(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    x_req = r; x_we = w; x_addr = a; x_wdata = d; x_be = be;
  endtask

  task automatic idle();
    set_c(0, 0, '0, '0, '0);
    set_x(0, 0, '0, '0, '0);
  endtask

  initial begin
    int x_first;
    nrst = 1'b0;
    idle();
    // requests held during reset must not be granted
    set_c(1, 0, 32'h10, 32'h0, 4'hF);
    set_x(1, 0, 32'h14, 32'h0, 4'hF);
    step(3);
    idle();
    nrst = 1'b1;
    step(2);

    // core-only read of 0x100
    set_c(1, 0, 32'h100, 32'h5555_5555, 4'hF);
    step(1);
    idle();
    step(2);

    // simultaneous requests from an empty count: X must wait 4 cycles
    set_c(1, 0, 32'h20, 32'h0, 4'hF);
    set_x(1, 0, 32'h24, 32'h0, 4'hF);
    x_first = -1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (x_gnt && x_first < 0) x_first = i;
      @(posedge clk); #1;
    end
    chk("starve_first_x_cycle", 32'(x_first), 32'd4);
    idle();
    step(2);

    // owner change on consecutive cycles: core write, then X read of it
    set_c(1, 1, 32'h8, 32'h1122_3344, 4'hF);
    step(1);
    set_c(0, 0, '0, '0, '0);
    set_x(1, 0, 32'h8, 32'h0, 4'hF);
    step(1);
    idle();
    step(2);

    // partial byte-enable write then read back
    set_c(1, 1, 32'hC, 32'hAABB_CCDD, 4'b0101);
    step(1);
    set_c(1, 0, 32'hC, 32'h0, 4'hF);
    step(1);
    idle();
    step(2);

    // X drops after 2 denied cycles, then needs 4 fresh denied cycles
    set_c(1, 0, 32'h30, 32'h0, 4'hF);
    set_x(1, 0, 32'h34, 32'h0, 4'hF);
    step(2);
    x_req = 1'b0;
    step(1);
    x_req = 1'b1;
    x_first = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (x_gnt && x_first < 0) x_first = i;
      @(posedge clk); #1;
    end
    chk("restart_first_x_cycle", 32'(x_first), 32'd4);
    idle();
    step(2);

    // reset in the cycle after a core read grant: response dropped
    set_c(1, 0, 32'h100, 32'h0, 4'hF);
    step(1);
    nrst = 1'b0;
    set_c(1, 0, 32'h40, 32'h0, 4'hF);
    set_x(1, 0, 32'h44, 32'h0, 4'hF);
    step(2);
    nrst = 1'b1;
    x_first = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (x_gnt && x_first < 0) x_first = i;
      @(posedge clk); #1;
    end
    chk("post_reset_first_x_cycle", 32'(x_first), 32'd4);
    idle();
    step(2);

    // random traffic; each side holds its request until granted
    for (int i = 0; i < 300; i++) begin
      if (!c_req || last_cg)
        set_c(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              {22'h0, 8'($urandom), 2'b00}, $urandom, 4'($urandom));
      if (!x_req || last_xg)
        set_x(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {22'h0, 8'($urandom), 2'b00}, $urandom, 4'($urandom));
      step(1);
    end
    idle();
    step(3);
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
